// File: rtl/idu_hazard_ctrl_pkg.sv
// Shared types and constants for the IDU1 issue/hazard controller.
package idu_hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  // Decoded issue payload, drivable straight from the IDU0 output register fields.
  typedef struct packed {
    logic                  valid;
    logic                  rs1;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic                  rs2;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic                  rd;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  load;
    logic                  div;
    logic                  mul;
  } hazard_issue_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  load;
  } hazard_wb_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    return NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/busy_counter.sv
// Down-counter occupancy tracker: loads a cycle count, counts to zero, flags busy.
module busy_counter #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // busy is kept as its own flop so it has no combinational input path
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      busy  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      busy  <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/idu_hazard_ctrl.sv
// IDU1 issue controller: register scoreboard, divider occupancy, load credit; drives stall/fire.
// Optional IDU_HAZARD_WB_BYPASS_EN lets a same-cycle writeback resolve a RAW/WAW hazard.
module idu_hazard_ctrl
  import idu_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 34,
  parameter int unsigned MAX_LOADS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_rs1,
  input  logic                  issue_rs2,
  input  logic [REG_ADDR_W-1:0] issue_rs1_addr,
  input  logic [REG_ADDR_W-1:0] issue_rs2_addr,
  input  logic                  issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rd_addr,
  input  logic                  issue_load,
  input  logic                  issue_div,
  input  logic                  issue_mul,
  input  logic                  pipe_flush,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_load,
  output logic                  pipe_stall,
  output logic                  issue_fire,
  output logic                  div_busy,
  output logic [NUM_REGS-1:0]   pending_mask
);

  localparam int unsigned DIV_W = $clog2(DIV_CYCLES);
  localparam int unsigned LD_W  = 3;

  hazard_issue_t iss;
  hazard_wb_t    wb;

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] wb_clr;
  logic [NUM_REGS-1:0] long_set;
  logic [NUM_REGS-1:0] hz_pend;
  logic [LD_W-1:0]     ld_cnt_q;
  logic                long_op;
  logic                raw1, raw2, waw, sdiv, sld;
  logic                div_fire, ld_inc, ld_dec;

  assign iss = '{valid: issue_valid, rs1: issue_rs1, rs1_addr: issue_rs1_addr,
                 rs2: issue_rs2, rs2_addr: issue_rs2_addr, rd: issue_rd,
                 rd_addr: issue_rd_addr, load: issue_load, div: issue_div,
                 mul: issue_mul};
  assign wb  = '{valid: wb_valid, rd_addr: wb_rd_addr, load: wb_load};

  // x0 is never tracked, so a writeback to it is a no-op
  always_comb begin
    wb_clr = '0;
    if (wb.valid) begin
      wb_clr = reg_onehot(wb.rd_addr);
    end
    wb_clr[0] = 1'b0;
  end

`ifdef IDU_HAZARD_WB_BYPASS_EN
  assign hz_pend = pending_q & ~wb_clr;
`else
  assign hz_pend = pending_q;
`endif

  assign long_op = iss.load | iss.div | iss.mul;
  assign raw1    = iss.rs1 & hz_pend[iss.rs1_addr];
  assign raw2    = iss.rs2 & hz_pend[iss.rs2_addr];
  assign waw     = iss.rd & hz_pend[iss.rd_addr];
  assign sdiv    = iss.div & div_busy;
  assign sld     = iss.load & (ld_cnt_q == LD_W'(MAX_LOADS));

  assign pipe_stall = ~pipe_flush & iss.valid & (raw1 | raw2 | waw | sdiv | sld);
  assign issue_fire = iss.valid & ~pipe_flush & ~pipe_stall;

  // Set after clear, so a same-register issue beats the writeback
  always_comb begin
    long_set = '0;
    if (issue_fire && long_op && iss.rd && (iss.rd_addr != '0)) begin
      long_set = reg_onehot(iss.rd_addr);
    end
    pending_d = (pending_q & ~wb_clr) | long_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_mask = pending_q;

  assign div_fire = issue_fire & iss.div;

  busy_counter #(
    .W (DIV_W)
  ) u_div_busy (
    .clk      (clk),
    .rst      (rst),
    .load     (div_fire),
    .load_val (DIV_W'(DIV_CYCLES - 1)),
    .busy     (div_busy)
  );

  assign ld_inc = issue_fire & iss.load;
  assign ld_dec = wb.valid & wb.load;

  // Saturating load credit; a simultaneous issue and writeback cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q <= '0;
    end else if (ld_inc && !ld_dec) begin
      if (ld_cnt_q != LD_W'(MAX_LOADS)) begin
        ld_cnt_q <= ld_cnt_q + LD_W'(1);
      end
    end else if (ld_dec && !ld_inc) begin
      if (ld_cnt_q != '0) begin
        ld_cnt_q <= ld_cnt_q - LD_W'(1);
      end
    end
  end

  // A load writeback with nothing in flight means the LSU handshake is broken
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(ld_dec && !ld_inc && (ld_cnt_q == '0)));
    end
  end

endmodule
